// File: rtl/phi2_step_if.sv
// phi2_step_if: front-panel, CPU bus and status signals of the PHI2 step controller
interface phi2_step_if;
  logic        run_i;
  logic        step_i;
  logic        instr_step_i;
  logic        sync_i;
  logic [15:0] a_i;
  logic        bp_en_i;
  logic [15:0] bp_addr_i;
  logic        phi2_o;
  logic        phi2_rise_o;
  logic        phi2_fall_o;
  logic        halted_o;
  logic        bp_hit_o;
  logic [1:0]  state_o;
  logic [15:0] cycles_o;
  modport master (
    output run_i, step_i, instr_step_i, sync_i, a_i, bp_en_i, bp_addr_i,
    input  phi2_o, phi2_rise_o, phi2_fall_o, halted_o, bp_hit_o, state_o, cycles_o
  );
  modport slave (
    input  run_i, step_i, instr_step_i, sync_i, a_i, bp_en_i, bp_addr_i,
    output phi2_o, phi2_rise_o, phi2_fall_o, halted_o, bp_hit_o, state_o, cycles_o
  );
endinterface

// File: rtl/phi2_step_controller.sv
// phi2_step_controller: PHI2 generator with free-run, cycle/instruction stepping and breakpoint halt
module phi2_step_controller #(
  parameter int HALF_PERIOD  = 6,
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  phi2_step_if.slave   bus
);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP_CYC = 2'b10, STEP_INS = 2'b11} state_t;
  localparam logic [7:0] PH_MAX = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] SC_MAX = 8'(SYNC_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [7:0]  ph_q, ph_d, sc_q, sc_d;
  logic [15:0] cyc_q, cyc_d;
  logic        phi2_q, phi2_d, rise_q, rise_d, fall_q, fall_d, bp_hit_q, bp_hit_d;
  logic        run_q, stp_s_q, stp_q;
  logic        step_edge, toggle, cyc_end, bp_match;
  // State and clock-generator registers; the step sampler resets high so a held key is ignored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= HALT;
      ph_q     <= '0;
      sc_q     <= '0;
      cyc_q    <= '0;
      phi2_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      run_q    <= 1'b0;
      stp_s_q  <= 1'b1;
      stp_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      sc_q     <= sc_d;
      cyc_q    <= cyc_d;
      phi2_q   <= phi2_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      bp_hit_q <= bp_hit_d;
      run_q    <= bus.run_i;
      stp_s_q  <= bus.step_i;
      stp_q    <= stp_s_q;
    end
  end
  // Phase counter, PHI2 edges and next state; transitions out of non-HALT states only at a cycle end
  always_comb begin
    step_edge = stp_s_q & ~stp_q;
    toggle    = (state_q != HALT) && (ph_q == PH_MAX);
    cyc_end   = toggle && phi2_q;
    bp_match  = bus.bp_en_i && bus.sync_i && (bus.a_i == bus.bp_addr_i);
    ph_d      = (state_q == HALT || toggle) ? 8'd0 : ph_q + 8'd1;
    phi2_d    = (state_q != HALT) && (phi2_q ^ toggle);
    rise_d    = toggle && !phi2_q;
    fall_d    = cyc_end;
    cyc_d     = cyc_q + 16'(cyc_end);
    sc_d      = (state_q == HALT) ? 8'd0 : sc_q + 8'(cyc_end);
    state_d   = state_q;
    bp_hit_d  = bp_hit_q && !(state_q == HALT && step_edge);
    case (state_q)
      HALT:     state_d = (run_q && !bp_hit_q) ? RUN :
                          step_edge ? (bus.instr_step_i ? STEP_INS : STEP_CYC) : HALT;
      RUN: begin
        bp_hit_d = bp_hit_q || (cyc_end && bp_match);
        state_d  = (cyc_end && (bp_match || !bus.run_i)) ? HALT : RUN;
      end
      STEP_CYC: state_d = cyc_end ? HALT : STEP_CYC;
      STEP_INS: state_d = (cyc_end && ((bus.sync_i && sc_q != 8'd0) || sc_q == SC_MAX)) ? HALT : STEP_INS;
      default:  state_d = HALT;
    endcase
  end
  assign bus.phi2_o      = phi2_q;
  assign bus.phi2_rise_o = rise_q;
  assign bus.phi2_fall_o = fall_q;
  assign bus.halted_o    = state_q == HALT;
  assign bus.bp_hit_o    = bp_hit_q;
  assign bus.state_o     = state_q;
  assign bus.cycles_o    = cyc_q;
endmodule

// File: tb/tb_phi2_step_controller.sv
// tb_phi2_step_controller: directed checks of stepping, free-run, breakpoint and reset behaviour
module tb_phi2_step_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  phi2_step_if bus ();
  phi2_step_if bus2 ();
  phi2_step_controller dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  phi2_step_controller #(.HALF_PERIOD(1), .SYNC_TIMEOUT(16)) dut2 (.clk_i(clk), .rst_i(rst2), .bus(bus2));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int n, hi, rises, falls, halt_at, ends;
    bus.run_i = 0; bus.step_i = 1; bus.instr_step_i = 0; bus.sync_i = 0;
    bus.a_i = 16'h0000; bus.bp_en_i = 0; bus.bp_addr_i = 16'h0000;
    bus2.run_i = 0; bus2.step_i = 0; bus2.instr_step_i = 0; bus2.sync_i = 0;
    bus2.a_i = 16'h0000; bus2.bp_en_i = 0; bus2.bp_addr_i = 16'h0000;
    tick(2);
    rst = 0;
    rises = 0; falls = 0; hi = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      rises += int'(bus.phi2_rise_o); falls += int'(bus.phi2_fall_o); hi += int'(bus.phi2_o);
    end
    chk("rst_phi2_high_samples", 32'(hi), 0);
    chk("rst_strobes", 32'(rises + falls), 0);
    chk("rst_halted", 32'(bus.halted_o), 1);
    chk("rst_cycles", 32'(bus.cycles_o), 0);
    chk("rst_bp_hit", 32'(bus.bp_hit_o), 0);
    chk("rst_state", 32'(bus.state_o), 0);
    bus.step_i = 0;
    tick(20);
    chk("rst_release_cycles", 32'(bus.cycles_o), 0);
    chk("rst_release_halted", 32'(bus.halted_o), 1);
    bus.run_i = 1;
    tick(2);
    chk("run_state", 32'(bus.state_o), 1);
    n = 0;
    while (!bus.phi2_o && n < 100) begin tick(1); n++; end
    chk("run_first_rise_delay", 32'(n), 6);
    chk("run_rise_strobe", 32'(bus.phi2_rise_o), 1);
    tick(1);
    chk("run_rise_width", 32'(bus.phi2_rise_o), 0);
    n = 1; hi = 2;
    while (!bus.phi2_rise_o && n < 100) begin tick(1); n++; hi += int'(bus.phi2_o && !bus.phi2_rise_o); end
    chk("run_period", 32'(n), 12);
    chk("run_high_samples", 32'(hi), 6);
    tick(3);
    bus.run_i = 0;
    tick(2);
    chk("drop_run_still_high", 32'(bus.phi2_o), 1);
    tick(1);
    chk("drop_run_fall", 32'(bus.phi2_o), 0);
    chk("drop_run_fall_strobe", 32'(bus.phi2_fall_o), 1);
    chk("drop_run_halted", 32'(bus.halted_o), 1);
    chk("drop_run_cycles", 32'(bus.cycles_o), 2);
    tick(1);
    chk("fall_width", 32'(bus.phi2_fall_o), 0);
    tick(20);
    chk("drop_run_stays_low", 32'(bus.phi2_o), 0);
    bus.instr_step_i = 0;
    bus.step_i = 1;
    tick(2);
    chk("cstep_state", 32'(bus.state_o), 2);
    rises = 0; falls = 0; halt_at = -1;
    for (int i = 1; i <= 500; i++) begin
      if (i == 3) bus.step_i = 0;
      if (i == 5) bus.step_i = 1;
      tick(1);
      rises += int'(bus.phi2_rise_o); falls += int'(bus.phi2_fall_o);
      if (bus.halted_o && halt_at < 0) halt_at = i;
    end
    chk("cstep_rises", 32'(rises), 1);
    chk("cstep_falls", 32'(falls), 1);
    chk("cstep_halt_at", 32'(halt_at), 12);
    chk("cstep_cycles", 32'(bus.cycles_o), 3);
    bus.step_i = 0; bus.instr_step_i = 1; bus.sync_i = 1;
    tick(2);
    bus.step_i = 1;
    tick(2);
    chk("istep_state", 32'(bus.state_o), 3);
    ends = 0; n = 0;
    while (n < 400) begin
      tick(1); n++;
      if (bus.phi2_fall_o) begin ends++; bus.sync_i = (ends + 1 == 3); end
      if (bus.halted_o) break;
    end
    chk("istep_cycles_run", 32'(ends), 3);
    chk("istep_cycles", 32'(bus.cycles_o), 6);
    bus.step_i = 0; bus.sync_i = 0;
    tick(2);
    bus.step_i = 1;
    tick(2);
    ends = 0; n = 0;
    while (n < 400) begin
      tick(1); n++;
      if (bus.phi2_fall_o) ends++;
      if (bus.halted_o) break;
    end
    chk("timeout_cycles_run", 32'(ends), 16);
    chk("timeout_cycles", 32'(bus.cycles_o), 22);
    bus.step_i = 0; bus.instr_step_i = 0;
    bus.bp_en_i = 1; bus.bp_addr_i = 16'h0203; bus.a_i = 16'h0200; bus.sync_i = 1;
    tick(2);
    bus.run_i = 1;
    tick(2);
    ends = 0; n = 0;
    while (n < 400) begin
      tick(1); n++;
      if (bus.phi2_fall_o) begin ends++; bus.a_i = 16'h0203; end
      if (bus.halted_o) break;
    end
    chk("bp_cycles_run", 32'(ends), 2);
    chk("bp_hit", 32'(bus.bp_hit_o), 1);
    tick(50);
    chk("bp_hold_halted", 32'(bus.halted_o), 1);
    chk("bp_hold_cycles", 32'(bus.cycles_o), 24);
    bus.a_i = 16'h0300;
    bus.step_i = 1;
    tick(2);
    chk("bp_step_state", 32'(bus.state_o), 2);
    chk("bp_cleared", 32'(bus.bp_hit_o), 0);
    tick(12);
    chk("bp_step_halted", 32'(bus.halted_o), 1);
    chk("bp_step_cycles", 32'(bus.cycles_o), 25);
    tick(1);
    chk("bp_resume_run", 32'(bus.state_o), 1);
    bus.run_i = 0;
    tick(30);
    chk("bp_final_halted", 32'(bus.halted_o), 1);
    chk("bp_final_cycles", 32'(bus.cycles_o), 26);
    rst2 = 0;
    tick(2);
    bus2.run_i = 1;
    tick(2);
    chk("h1_state", 32'(bus2.state_o), 1);
    chk("h1_phi2_entry", 32'(bus2.phi2_o), 0);
    for (int i = 1; i <= 41; i++) begin
      tick(1);
      chk("h1_phi2_toggle", 32'(bus2.phi2_o), 32'(i % 2));
      if (i == 40) chk("h1_cycles", 32'(bus2.cycles_o), 20);
    end
    rst2 = 1;
    tick(1);
    chk("h1_reset_phi2", 32'(bus2.phi2_o), 0);
    chk("h1_reset_cycles", 32'(bus2.cycles_o), 0);
    chk("h1_reset_state", 32'(bus2.state_o), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
